// File: rtl/branch_issue_if.sv
// rtl/branch_issue_if.sv - instruction, CPSR read and branch-unit signals of branch_issue
interface branch_issue_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        cpsr_read_en;
    logic [31:0] cpsr_read_value;
    logic        br_en;
    logic        br_cond;
    logic        br_link;
    logic [23:0] br_offset;
    logic        done;
    logic        taken;
    logic        nonbranch;

    // Instruction source, register file and branch unit side
    modport master (
        output instr_valid,
        output instr,
        output cpsr_read_value,
        input  instr_ready,
        input  cpsr_read_en,
        input  br_en,
        input  br_cond,
        input  br_link,
        input  br_offset,
        input  done,
        input  taken,
        input  nonbranch
    );

    // Issue stage side
    modport slave (
        input  instr_valid,
        input  instr,
        input  cpsr_read_value,
        output instr_ready,
        output cpsr_read_en,
        output br_en,
        output br_cond,
        output br_link,
        output br_offset,
        output done,
        output taken,
        output nonbranch
    );
endinterface

// File: rtl/branch_issue.sv
// rtl/branch_issue.sv - ARM7 B/BL issue stage: CPSR read, condition check, timed branch-unit drive
module branch_issue #(
    parameter int EN_HOLD       = 2,
    parameter int SETTLE_CYCLES = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_issue_if.slave bus
);

    // Counter only ever holds a remaining count below the longest window
    localparam int MAXC = (EN_HOLD > SETTLE_CYCLES) ? EN_HOLD : SETTLE_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WT     = 3'd2,
        EVAL   = 3'd3,
        ISSUE  = 3'd4,
        SETTLE = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   instr_q;
    logic          accept;
    logic          is_branch;
    logic          cond_now;
    logic          unused_bits;

    // ARM condition-field evaluation against NZCV
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        r  = 1'b0;
        case (c)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = cf;
            4'h3:    r = !cf;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = cf & !z;
            4'h9:    r = !cf | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign bus.instr_ready = (state == IDLE) & rst_n;
    assign accept          = bus.instr_valid & bus.instr_ready;
    assign is_branch       = (bus.instr[27:25] == 3'b101);
    // Flags are taken straight off the read port at the end of WT, so the
    // condition result is registered on the same edge the flags are captured.
    assign cond_now        = cond_pass(instr_q[31:28], bus.cpsr_read_value[31:28]);
    assign unused_bits     = ^{instr_q[27:25], bus.cpsr_read_value[27:0]};

    // Issue sequencer: EVAL is the first br_en cycle, ISSUE carries the rest of
    // the hold window, SETTLE waits before the done pulse returns us to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            instr_q          <= '0;
            bus.cpsr_read_en <= 1'b0;
            bus.br_en        <= 1'b0;
            bus.br_cond      <= 1'b0;
            bus.br_link      <= 1'b0;
            bus.br_offset    <= '0;
            bus.done         <= 1'b0;
            bus.taken        <= 1'b0;
            bus.nonbranch    <= 1'b0;
        end else begin
            bus.cpsr_read_en <= 1'b0;
            bus.done         <= 1'b0;
            bus.taken        <= 1'b0;
            bus.nonbranch    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q <= bus.instr;
                        if (is_branch) begin
                            state            <= RD;
                            bus.cpsr_read_en <= 1'b1;
                        end else begin
                            bus.nonbranch <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state <= WT;
                end
                WT: begin
                    bus.br_cond   <= cond_now;
                    bus.br_link   <= instr_q[24];
                    bus.br_offset <= instr_q[23:0];
                    bus.br_en     <= 1'b1;
                    cnt           <= CW'(EN_HOLD - 1);
                    state         <= EVAL;
                end
                EVAL, ISSUE: begin
                    if (cnt == '0) begin
                        bus.br_en <= 1'b0;
                        cnt       <= CW'(SETTLE_CYCLES - 1);
                        state     <= SETTLE;
                    end else begin
                        cnt   <= cnt - CW'(1);
                        state <= ISSUE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        bus.done  <= 1'b1;
                        bus.taken <= bus.br_cond;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_issue.sv
// tb/tb_branch_issue.sv - directed self-checking bench for branch_issue
module tb_branch_issue;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [31:0] pc;
    logic [31:0] lr;

    branch_issue_if bus ();

    branch_issue #(.EN_HOLD(2), .SETTLE_CYCLES(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Independent NZCV condition model: base test on c[3:1], c[0] inverts, NV never passes
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cc;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cc & ~z;
            3'd5:    base = n ~^ v;
            3'd6:    base = ~z & (n ~^ v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return base ^ c[0];
    endfunction

    // Offer one instruction while the DUT is idle and trace cycles 0..16 after acceptance.
    // The CPSR port carries the true value only in cycle 1, matching the read contract.
    task automatic issue(input logic [31:0] ins, input logic [31:0] cpsr,
                         output logic [16:0] rd_t, output logic [16:0] en_t,
                         output logic [16:0] dn_t, output logic c2, output logic l2,
                         output logic [23:0] o2, output logic tk, output logic rdy);
        logic [31:0] sext;
        rd_t = '0; en_t = '0; dn_t = '0;
        c2 = 1'b0; l2 = 1'b0; o2 = '0; tk = 1'b0; rdy = 1'b0;
        bus.instr           = ins;
        bus.instr_valid     = 1'b1;
        bus.cpsr_read_value = ~cpsr;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'hFFFF_FFFF;
        for (int k = 0; k <= 16; k++) begin
            bus.cpsr_read_value = (k == 1) ? cpsr : ~cpsr;
            rd_t[k] = bus.cpsr_read_en;
            en_t[k] = bus.br_en;
            dn_t[k] = bus.done;
            if (k == 2) begin
                c2 = bus.br_cond;
                l2 = bus.br_link;
                o2 = bus.br_offset;
                // Branch unit: PC+8 relative target, link saves PC+4, not taken steps PC by 4
                sext = {{6{bus.br_offset[23]}}, bus.br_offset, 2'b00};
                if (bus.br_en && bus.br_cond) begin
                    if (bus.br_link) lr = pc + 32'd4;
                    pc = pc + 32'd8 + sext;
                end else if (bus.br_en) begin
                    pc = pc + 32'd4;
                end
            end
            if (k == 16) begin
                tk  = bus.taken;
                rdy = bus.instr_ready;
            end
            if (k < 16) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] rd_t, en_t, dn_t;
        logic        c2, l2, tk, rdy, acc;
        logic [23:0] o2;

        n_checks = 0;
        n_pass   = 0;
        pc       = 32'h0;
        lr       = 32'h0;

        // Reset held for 3 cycles with an instruction offered
        rst_n               = 1'b0;
        bus.instr_valid     = 1'b1;
        bus.instr           = 32'hEA00_0003;
        bus.cpsr_read_value = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_outputs",
                  {4'h0, bus.instr_ready, bus.cpsr_read_en, bus.br_en, bus.br_cond,
                   bus.br_link, bus.done, bus.taken, bus.nonbranch, bus.br_offset},
                  32'h0);
        end
        bus.instr_valid = 1'b0;
        rst_n           = 1'b1;
        #1;
        check("ready_after_release", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        check("no_accept_in_reset", {30'h0, bus.cpsr_read_en, bus.instr_ready}, 32'h1);

        // BAL, flags clear
        pc = 32'h1004;
        issue(32'hEA00_0003, 32'h0, rd_t, en_t, dn_t, c2, l2, o2, tk, rdy);
        check("bal_rd_trace",   32'(rd_t), 32'h0_0001);
        check("bal_en_trace",   32'(en_t), 32'h0_000C);
        check("bal_done_trace", 32'(dn_t), 32'h1_0000);
        check("bal_cond",       32'(c2),   32'd1);
        check("bal_link",       32'(l2),   32'd0);
        check("bal_offset",     32'(o2),   32'h00_0003);
        check("bal_taken",      32'(tk),   32'd1);
        check("bal_ready_done", 32'(rdy),  32'd1);
        check("bal_pc",         pc,        32'h1018);

        // BLEQ with Z clear: issued not taken, back-to-back accept in done cycle
        pc = 32'h3000;
        issue(32'h0BFF_FFFE, 32'h0, rd_t, en_t, dn_t, c2, l2, o2, tk, rdy);
        check("bleq0_en_trace", 32'(en_t), 32'h0_000C);
        check("bleq0_done",     32'(dn_t), 32'h1_0000);
        check("bleq0_cond",     32'(c2),   32'd0);
        check("bleq0_link",     32'(l2),   32'd1);
        check("bleq0_offset",   32'(o2),   32'hFF_FFFE);
        check("bleq0_taken",    32'(tk),   32'd0);
        check("bleq0_pc",       pc,        32'h3004);

        // BLEQ with Z set: taken branch to self, link written
        pc = 32'h2000;
        lr = 32'h0;
        issue(32'h0BFF_FFFE, 32'h4000_0000, rd_t, en_t, dn_t, c2, l2, o2, tk, rdy);
        check("bleq1_cond",  32'(c2), 32'd1);
        check("bleq1_taken", 32'(tk), 32'd1);
        check("bleq1_lr",    lr,      32'h2004);
        check("bleq1_pc",    pc,      32'h2000);

        // Condition sweep: every cond code against every NZCV value
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                issue({c[3:0], 4'b1010, 24'h00_0010}, {f[3:0], 28'h0},
                      rd_t, en_t, dn_t, c2, l2, o2, tk, rdy);
                check($sformatf("sweep_cond_c%0h_f%0h", c, f), 32'(c2),
                      32'(model_cond(c[3:0], f[3:0])));
                check($sformatf("sweep_taken_c%0h_f%0h", c, f), 32'(tk),
                      32'(model_cond(c[3:0], f[3:0])));
            end
        end

        // Non-branch: immediate retire, second accept on the following edge
        bus.instr       = 32'hE1A0_0000;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        check("nb_pulse0", {28'h0, bus.nonbranch, bus.instr_ready, bus.cpsr_read_en, bus.br_en},
              32'b1100);
        bus.instr = 32'hE3A0_1001;
        @(posedge clk); #1;
        check("nb_pulse1", {29'h0, bus.nonbranch, bus.instr_ready, bus.cpsr_read_en}, 32'b110);
        bus.instr_valid = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            acc = acc | bus.nonbranch | bus.cpsr_read_en | bus.br_en | bus.done;
        end
        check("nb_quiet", 32'(acc), 32'd0);

        // Reset in the first br_en cycle aborts the issue with no done
        bus.instr           = 32'hEA00_0003;
        bus.cpsr_read_value = 32'h0;
        bus.instr_valid     = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_en_before", 32'(bus.br_en), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_en_after", {30'h0, bus.br_en, bus.instr_ready}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_idle", 32'(bus.instr_ready), 32'd1);
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            acc = acc | bus.done | bus.br_en | bus.cpsr_read_en;
        end
        check("abort_no_done", 32'(acc), 32'd0);

        pc = 32'h1004;
        issue(32'hEA00_0003, 32'h0, rd_t, en_t, dn_t, c2, l2, o2, tk, rdy);
        check("post_abort_en",   32'(en_t), 32'h0_000C);
        check("post_abort_done", 32'(dn_t), 32'h1_0000);
        check("post_abort_pc",   pc,        32'h1018);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
